// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared defaults, FSM encodings and small helpers for the
// data-memory arbiter. Optional feature macro used by the arbiter:
// DMEM_ARB_RR_EN (round-robin arbitration outside a locked M1 burst).
package dmem_arbiter_pkg;

   // Default word-address width (256 words) and data width of dmem
   localparam int DMEM_AW        = 8;
   localparam int DMEM_DW        = 32;
   // Default number of consecutive locked M1 grants before M0 is served
   localparam int DMEM_BURST_MAX = 8;
   // Burst counter width; holds BURST_MAX up to 255
   localparam int ARB_CNT_W      = 8;

   // Arbiter FSM encodings
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_e;

   // Identity of a requester, used by the round-robin last-grant flop
   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } arb_mst_e;

   // True while a locked M1 burst may still take another grant
   function automatic logic burst_open(input logic [ARB_CNT_W-1:0] cnt,
                                       input logic [ARB_CNT_W-1:0] max_cnt);
      return (cnt < max_cnt);
   endfunction

endpackage

// File: rtl/dmem_arb_rdret.sv
// dmem_arb_rdret: per-master read-return stage. Registers the async dmem
// read data on a granted read and presents it with a one-cycle valid pulse.
// The data register holds its last value while no read returns.
module dmem_arb_rdret
   import dmem_arbiter_pkg::*;
#(
   parameter int DW = DMEM_DW
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_rd,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   // Capture read data on a granted read; valid pulses for exactly one cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= {DW{1'b0}};
      end else begin
         r_valid <= i_rd;
         if (i_rd) begin
            r_data <= i_data;
         end else begin
            r_data <= r_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the core load/store
// path (M0) and the loader/debug DMA port (M1). Grants are combinational
// from the registered FSM state and the live requests; the granted
// master's controls are muxed straight onto the dmem port.
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin arbitration
// outside a locked M1 burst (fixed M0 priority when undefined).
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW        = DMEM_AW,
   parameter int DW        = DMEM_DW,
   parameter int BURST_MAX = DMEM_BURST_MAX
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_gnt_o,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   input  logic          m1_lock_i,
   output logic          m1_gnt_o,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_a_o,
   output logic [DW-1:0] mem_d_o,
   input  logic [DW-1:0] mem_spo_i
);

   localparam logic [ARB_CNT_W-1:0] LP_BMAX = ARB_CNT_W'(BURST_MAX);

   arb_state_e           r_state;
   arb_state_e           w_state_nxt;
   logic [ARB_CNT_W-1:0] r_cnt;
   logic [ARB_CNT_W-1:0] w_cnt_nxt;
   logic                 w_gnt0;
   logic                 w_gnt1;
   logic                 w_m0_wins;

`ifdef DMEM_ARB_RR_EN
   arb_mst_e             r_last;

   // On contention outside a burst, the master not granted last time wins
   assign w_m0_wins = m0_req_i & (~m1_req_i | (r_last == MST_M1));

   // Track the most recently granted master; reset favours M0 first
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_last <= MST_M1;
      end else if (w_gnt0) begin
         r_last <= MST_M0;
      end else if (w_gnt1) begin
         r_last <= MST_M1;
      end else begin
         r_last <= r_last;
      end
   end
`else
   // Fixed priority: M0 always wins outside a burst
   assign w_m0_wins = m0_req_i;
`endif

   // FSM state and burst counter registers
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= ARB_IDLE;
         r_cnt   <= {ARB_CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Grant selection and next-state logic; no grant while reset is asserted
   always_comb begin
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!rst_i) begin
         w_state_nxt = ARB_IDLE;
         w_cnt_nxt   = {ARB_CNT_W{1'b0}};
      end else begin
         case (r_state)
            ARB_IDLE, ARB_OWN0: begin
               w_state_nxt = ARB_IDLE;
               w_cnt_nxt   = {ARB_CNT_W{1'b0}};
               if (w_m0_wins) begin
                  w_gnt0 = 1'b1;
               end else if (m1_req_i) begin
                  w_gnt1 = 1'b1;
                  if (m1_lock_i) begin
                     w_state_nxt = ARB_OWN1;
                     w_cnt_nxt   = 8'd1;
                  end else begin
                     w_state_nxt = ARB_IDLE;
                  end
               end else begin
                  w_state_nxt = ARB_IDLE;
               end
            end
            ARB_OWN1: begin
               if (m1_lock_i && burst_open(r_cnt, LP_BMAX)) begin
                  if (m1_req_i) begin
                     w_gnt1    = 1'b1;
                     w_cnt_nxt = r_cnt + 8'd1;
                  end else begin
                     w_cnt_nxt = r_cnt;
                  end
               end else begin
                  // Lock released or burst exhausted: hand priority to M0
                  w_state_nxt = ARB_OWN0;
                  w_cnt_nxt   = {ARB_CNT_W{1'b0}};
               end
            end
            default: begin
               w_state_nxt = ARB_IDLE;
               w_cnt_nxt   = {ARB_CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Mux the granted master onto the dmem port; idle port drives zeros
   always_comb begin
      mem_we_o = 1'b0;
      mem_a_o  = {AW{1'b0}};
      mem_d_o  = {DW{1'b0}};
      if (w_gnt0) begin
         mem_we_o = m0_we_i;
         mem_a_o  = m0_addr_i;
         mem_d_o  = m0_wdata_i;
      end else if (w_gnt1) begin
         mem_we_o = m1_we_i;
         mem_a_o  = m1_addr_i;
         mem_d_o  = m1_wdata_i;
      end else begin
         mem_we_o = 1'b0;
      end
   end

   assign m0_gnt_o = w_gnt0;
   assign m1_gnt_o = w_gnt1;

   dmem_arb_rdret #(.DW(DW)) u_rdret_m0 (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_rd    (w_gnt0 & ~m0_we_i),
      .i_data  (mem_spo_i),
      .o_valid (m0_rvalid_o),
      .o_data  (m0_rdata_o)
   );

   dmem_arb_rdret #(.DW(DW)) u_rdret_m1 (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_rd    (w_gnt1 & ~m1_we_i),
      .i_data  (mem_spo_i),
      .o_valid (m1_rvalid_o),
      .o_data  (m1_rdata_o)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors drive the arbiter cycle by cycle; each
// vector pushes its expected grant and any expected read return into
// queues, and a monitor on the falling edge pops and compares them.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
   logic [7:0]  m0_addr_i, m1_addr_i;
   logic [31:0] m0_wdata_i, m1_wdata_i;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_we_o;
   logic [7:0]  mem_a_o;
   logic [31:0] mem_d_o;
   logic [31:0] mem_spo_i;

   logic [31:0] dmem    [0:255];
   logic [31:0] ref_mem [0:255];

   typedef struct {
      int          cyc;
      int          who;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] data;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } rexp_t;

   gexp_t q_g[$];
   rexp_t q_r0[$];
   rexp_t q_r1[$];

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .m0_req_i    (m0_req_i),
      .m0_we_i     (m0_we_i),
      .m0_addr_i   (m0_addr_i),
      .m0_wdata_i  (m0_wdata_i),
      .m0_gnt_o    (m0_gnt_o),
      .m0_rvalid_o (m0_rvalid_o),
      .m0_rdata_o  (m0_rdata_o),
      .m1_req_i    (m1_req_i),
      .m1_we_i     (m1_we_i),
      .m1_addr_i   (m1_addr_i),
      .m1_wdata_i  (m1_wdata_i),
      .m1_lock_i   (m1_lock_i),
      .m1_gnt_o    (m1_gnt_o),
      .m1_rvalid_o (m1_rvalid_o),
      .m1_rdata_o  (m1_rdata_o),
      .mem_we_o    (mem_we_o),
      .mem_a_o     (mem_a_o),
      .mem_d_o     (mem_d_o),
      .mem_spo_i   (mem_spo_i)
   );

   // Bench-side dmem: async read, sync write
   assign mem_spo_i = dmem[mem_a_o];
   always @(posedge clk) begin
      if (mem_we_o) dmem[mem_a_o] <= mem_d_o;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] bd(input logic [7:0] a);
      return 32'hB000_0000 | {24'h0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Apply one cycle of stimulus and queue its expected outcome
   // who: 0 = no grant, 1 = M0 granted, 2 = M1 granted
   task automatic step(input logic rst,
                       input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic lk, input int who);
      gexp_t g;
      rexp_t r;
      @(posedge clk);
      #1;
      rst_i = rst;
      m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
      m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
      m1_lock_i = lk;
      g.cyc = cyc; g.who = who; g.we = 1'b0; g.addr = 8'h00; g.data = 32'h0;
      if (who == 1) begin
         g.we = w0; g.addr = a0; g.data = d0;
      end else if (who == 2) begin
         g.we = w1; g.addr = a1; g.data = d1;
      end
      q_g.push_back(g);
      if (who != 0) begin
         if (g.we) begin
            ref_mem[g.addr] = g.data;
         end else begin
            r.cyc = cyc + 1;
            r.data = ref_mem[g.addr];
            if (who == 1) q_r0.push_back(r);
            else q_r1.push_back(r);
         end
      end
   endtask

   // Monitor: compare grants, dmem port and read returns every cycle
   always @(negedge clk) begin
      gexp_t g;
      rexp_t r;
      if (mon_en) begin
         if (q_g.size() > 0 && q_g[0].cyc == cyc) begin
            g = q_g.pop_front();
            chk("m0_gnt", {31'h0, m0_gnt_o}, {31'h0, g.who == 1});
            chk("m1_gnt", {31'h0, m1_gnt_o}, {31'h0, g.who == 2});
            chk("mem_we", {31'h0, mem_we_o}, {31'h0, g.we});
            if (g.who != 0) begin
               chk("mem_a", {24'h0, mem_a_o}, {24'h0, g.addr});
               if (g.we) chk("mem_d", mem_d_o, g.data);
            end
         end else begin
            chk("idle_gnt", {30'h0, m0_gnt_o, m1_gnt_o}, 32'h0);
            chk("idle_we", {31'h0, mem_we_o}, 32'h0);
         end
         if (q_r0.size() > 0 && q_r0[0].cyc == cyc) begin
            r = q_r0.pop_front();
            chk("m0_rvalid", {31'h0, m0_rvalid_o}, 32'h1);
            chk("m0_rdata", m0_rdata_o, r.data);
         end else begin
            chk("m0_rvalid_low", {31'h0, m0_rvalid_o}, 32'h0);
         end
         if (q_r1.size() > 0 && q_r1[0].cyc == cyc) begin
            r = q_r1.pop_front();
            chk("m1_rvalid", {31'h0, m1_rvalid_o}, 32'h1);
            chk("m1_rdata", m1_rdata_o, r.data);
         end else begin
            chk("m1_rvalid_low", {31'h0, m1_rvalid_o}, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         dmem[i]    = 32'hA500_0000 | i;
         ref_mem[i] = 32'hA500_0000 | i;
      end
      rst_i = 1'b0;
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 8'h00; m0_wdata_i = 32'h0;
      m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 8'h00; m1_wdata_i = 32'h0;
      m1_lock_i = 1'b0;

      // Reset held 3 cycles with both requests high
      step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 0);
      mon_en = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 0);
      @(negedge clk); #1;
      chk("rst_m0_rdata", m0_rdata_o, 32'h0);
      chk("rst_m1_rdata", m1_rdata_o, 32'h0);

      // M0 write then read back
      step(1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1);
      step(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 0);

      // M1 alone, then two rounds of simultaneous reads
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 2);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 1);
         step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 2);
      end

      // Locked burst of 12 writes with M0 waiting: 8 M1, gap, M0, M1 resumes
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h20, bd(8'h20), 1'b1, 2);
      for (int i = 1; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b1, 8'(8'h20 + i), bd(8'(8'h20 + i)), 1'b1, 2);
      end
      step(1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b1, 8'h28, bd(8'h28), 1'b1, 0);
      step(1'b1, 1'b1, 1'b0, 8'h30, 32'h0, 1'b1, 1'b1, 8'h28, bd(8'h28), 1'b1, 1);
      for (int i = 8; i < 12; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'(8'h20 + i), bd(8'(8'h20 + i)), 1'b1, 2);
      end
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 0);

      // Lock dropped after 3 grants: exit cycle, then M0, then M1 unlocked
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'(8'h40 + i), bd(8'(8'h40 + i)), 1'b1, 2);
      end
      step(1'b1, 1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b1, 8'h43, bd(8'h43), 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 1'b1, 8'h43, bd(8'h43), 1'b0, 1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h43, bd(8'h43), 1'b0, 2);

      // Reset mid-burst at cnt=4: no grant and no write in the reset cycle
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'(8'h50 + i), bd(8'(8'h50 + i)), 1'b1, 2);
      end
      step(1'b0, 1'b1, 1'b0, 8'h54, 32'h0, 1'b1, 1'b1, 8'h54, bd(8'h54), 1'b1, 0);
      // Back in IDLE: M0 wins over locked M1 and sees the old word at 0x54
      step(1'b1, 1'b1, 1'b0, 8'h54, 32'h0, 1'b1, 1'b1, 8'h54, bd(8'h54), 1'b1, 1);
      @(negedge clk); #1;
      chk("midrst_m1_rdata", m1_rdata_o, 32'h0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h54, bd(8'h54), 1'b1, 2);
      step(1'b1, 1'b1, 1'b0, 8'h54, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 8'h54, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1);

      // Drain
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 0);
      end
      @(negedge clk); #1;
      chk("q_gnt_empty", q_g.size(), 32'h0);
      chk("q_rv_empty", q_r0.size() + q_r1.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
